// File: rtl/spi_transaction_seq.sv
// spi_transaction_seq: multi-byte SPI transaction sequencer in front of spi_master.
// Owns one chip select for a whole command, keeps a single byte in flight in the
// master and returns received bytes through a one-entry RX buffer.
// Build option: define SPI_SEQ_CS_GUARD_EN to add GUARD-cycle chip-select setup/hold.
module spi_transaction_seq #(
  parameter int unsigned NCS   = 2,
  parameter int unsigned LEN_W = 16,
  parameter int unsigned GUARD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [$clog2(NCS)-1:0]  cmd_cs,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic [7:0]              tx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [7:0]              rx_data,
  output logic                    busy,
  output logic [NCS-1:0]          cs_n,
  output logic                    spi_req,
  input  logic                    spi_ready,
  input  logic                    spi_done,
  output logic [7:0]              spi_tx,
  input  logic [7:0]              spi_rx
);

  localparam int unsigned CsW = $clog2(NCS);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StIssue,
    StWaitDone,
    StHold
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [NCS-1:0]   cs_n_q, cs_n_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;

`ifdef SPI_SEQ_CS_GUARD_EN
  localparam int unsigned GuardW   = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [GuardW-1:0] GuardMax = GuardW'(GUARD - 1);

  logic [GuardW-1:0] guard_q, guard_d;
`else
  // Parameter has no effect in this build; keep it referenced.
  logic [31:0] unused_guard;
  assign unused_guard = GUARD;
`endif

  // Next-state, datapath updates and handshake decode
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cs_n_d     = cs_n_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
`ifdef SPI_SEQ_CS_GUARD_EN
    guard_d    = guard_q;
`endif
    cmd_ready  = 1'b0;
    spi_req    = 1'b0;
    tx_ready   = 1'b0;

    // Drain first; a fill below can only happen when the buffer is already empty.
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          rem_d = cmd_len;
          // Out-of-range index leaves every select deasserted.
          for (int i = 0; i < NCS; i++) begin
            cs_n_d[i] = (cmd_cs != CsW'(i));
          end
`ifdef SPI_SEQ_CS_GUARD_EN
          guard_d = '0;
          state_d = StSetup;
`else
          state_d = StIssue;
`endif
        end
      end
`ifdef SPI_SEQ_CS_GUARD_EN
      StSetup: begin
        if (guard_q == GuardMax) begin
          guard_d = '0;
          state_d = StIssue;
        end else begin
          guard_d = guard_q + GuardW'(1);
        end
      end
`endif
      StIssue: begin
        // Only issue into an empty RX buffer so the returning byte always has room.
        spi_req  = tx_valid & ~rx_valid_q;
        tx_ready = spi_req & spi_ready;
        if (tx_ready) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (spi_done) begin
          rx_data_d  = spi_rx;
          rx_valid_d = 1'b1;
          if (rem_q == '0) begin
`ifdef SPI_SEQ_CS_GUARD_EN
            guard_d = '0;
            state_d = StHold;
`else
            cs_n_d  = '1;
            state_d = StIdle;
`endif
          end else begin
            rem_d   = rem_q - LEN_W'(1);
            state_d = StIssue;
          end
        end
      end
`ifdef SPI_SEQ_CS_GUARD_EN
      StHold: begin
        if (guard_q == GuardMax) begin
          guard_d = '0;
          cs_n_d  = '1;
          state_d = StIdle;
        end else begin
          guard_d = guard_q + GuardW'(1);
        end
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      cs_n_q     <= '1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
`ifdef SPI_SEQ_CS_GUARD_EN
      guard_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      cs_n_q     <= cs_n_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
`ifdef SPI_SEQ_CS_GUARD_EN
      guard_q    <= guard_d;
`endif
    end
  end

  assign busy     = (state_q != StIdle);
  assign cs_n     = cs_n_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign spi_tx   = tx_data;

endmodule

// File: tb/tb_spi_transaction_seq.sv
// tb_spi_transaction_seq: scoreboard bench for spi_transaction_seq with a loopback
// model of spi_master (fixed latency, echoes the transmitted byte).
module tb_spi_transaction_seq;

  localparam int unsigned NCS   = 2;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned GUARD = 4;
`ifdef SPI_SEQ_CS_GUARD_EN
  localparam int GEFF = GUARD;
`else
  localparam int GEFF = 0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic [$clog2(NCS)-1:0] cmd_cs = '0;
  logic [LEN_W-1:0]       cmd_len = '0;
  logic                   tx_valid = 1'b0;
  logic                   tx_ready;
  logic [7:0]             tx_data = '0;
  logic                   rx_valid;
  logic                   rx_ready = 1'b1;
  logic [7:0]             rx_data;
  logic                   busy;
  logic [NCS-1:0]         cs_n;
  logic                   spi_req;
  logic                   spi_ready;
  logic                   spi_done;
  logic [7:0]             spi_tx;
  logic [7:0]             spi_rx;

  always #5 clk = ~clk;

  spi_transaction_seq #(
    .NCS   (NCS),
    .LEN_W (LEN_W),
    .GUARD (GUARD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_cs    (cmd_cs),
    .cmd_len   (cmd_len),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .busy      (busy),
    .cs_n      (cs_n),
    .spi_req   (spi_req),
    .spi_ready (spi_ready),
    .spi_done  (spi_done),
    .spi_tx    (spi_tx),
    .spi_rx    (spi_rx)
  );

  // Loopback spi_master model: accepts on req&ready, echoes the byte after m_lat cycles.
  int         m_lat = 12;
  logic       m_busy;
  int         m_cnt;
  logic [7:0] m_byte;
  assign spi_ready = ~m_busy;

  always @(posedge clk) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_cnt    <= 0;
      m_byte   <= '0;
      spi_done <= 1'b0;
      spi_rx   <= '0;
    end else begin
      spi_done <= 1'b0;
      if (!m_busy) begin
        if (spi_req) begin
          m_busy <= 1'b1;
          m_cnt  <= m_lat;
          m_byte <= spi_tx;
        end
      end else if (m_cnt == 0) begin
        m_busy   <= 1'b0;
        spi_done <= 1'b1;
        spi_rx   <= m_byte;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_bytes[16];

  // Per-transaction observations filled by run_txn
  int c_cmd, c_cslow, c_req, c_done, c_cshigh, n_txhs, n_rx;
  bit cs_bad, overlap, stall_bad, stall_seen, pause_bad, pause_seen;

  task automatic run_txn(input int cs, input int len, input int rx_hold, input int tx_pause);
    int             n;
    int             tx_i;
    int             rx_i;
    int             hold_cnt;
    int             pause_cnt;
    int             start;
    bit             cmd_done;
    bit             fin;
    logic [7:0]     exp;
    logic [NCS-1:0] cs_exp;
    n = len + 1;
    tx_i = 0; rx_i = 0; hold_cnt = 0; pause_cnt = 0; start = cyc;
    cmd_done = 1'b0; fin = 1'b0;
    cs_exp = ~(NCS'(1) << cs);
    c_cmd = -1; c_cslow = -1; c_req = -1; c_done = -1; c_cshigh = -1;
    n_txhs = 0; n_rx = 0;
    cs_bad = 0; overlap = 0; stall_bad = 0; stall_seen = 0; pause_bad = 0; pause_seen = 0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      cmd_valid = !cmd_done;
      cmd_cs    = cs[$clog2(NCS)-1:0];
      cmd_len   = len[LEN_W-1:0];
      tx_valid  = cmd_done && !(tx_i == 1 && pause_cnt < tx_pause);
      tx_data   = (tx_i < n) ? tx_bytes[tx_i] : 8'hEE;
      rx_ready  = !(rx_i == 1 && hold_cnt < rx_hold);
      #1;
      if (cmd_valid && cmd_ready) begin
        c_cmd = cyc;
        cmd_done = 1'b1;
      end
      if (cmd_done && tx_i == 1 && pause_cnt < tx_pause) begin
        pause_cnt++;
        if (pause_cnt == tx_pause) pause_seen = 1;
        if (cs_n !== cs_exp || spi_req !== 1'b0) pause_bad = 1;
      end
      if (rx_i == 1 && hold_cnt < rx_hold) begin
        hold_cnt++;
        if (rx_valid) stall_seen = 1;
        if (rx_valid && spi_req) stall_bad = 1;
      end
      if (cs_n !== '1 && c_cslow < 0) c_cslow = cyc;
      if (c_cslow >= 0 && c_cshigh < 0) begin
        if (cs_n === '1) c_cshigh = cyc;
        else if (cs_n !== cs_exp) cs_bad = 1;
      end
      if ($countones(~cs_n) > 1) cs_bad = 1;
      if (spi_req && c_req < 0) c_req = cyc;
      if (spi_done) begin
        c_done = cyc;
        if (spi_req) overlap = 1;
      end
      if (tx_valid && tx_ready) begin
        n_txhs++;
        if (tx_i < n) begin
          exp_q.push_back(tx_bytes[tx_i]);
          tx_i++;
        end
      end
      if (rx_valid && rx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: got %h, expected no byte", rx_data);
        end else begin
          exp = exp_q.pop_front();
          if (rx_data !== exp) begin
            errors++;
            $display("FAIL rx_data[%0d]: got %h, expected %h", rx_i, rx_data, exp);
          end
        end
        rx_i++;
        n_rx++;
      end
      if (cmd_done && rx_i == n && c_cshigh >= 0 && !busy) fin = 1'b1;
      if (cyc - start > 3000) begin
        checks++;
        errors++;
        $display("FAIL txn_timeout: rx %0d of %0d bytes, busy=%b", rx_i, n, busy);
        fin = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    tx_valid  = 1'b0;
    rx_ready  = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rx_missing: %0d bytes never returned, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (cs_n !== '1 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_regs: cs_n=%b rx_valid=%b rx_data=%h, expected 11/0/00",
               cs_n, rx_valid, rx_data);
    end
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || spi_req !== 1'b0 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: cmd_ready=%b busy=%b spi_req=%b tx_ready=%b, expected 1/0/0/0",
               cmd_ready, busy, spi_req, tx_ready);
    end
    tx_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C; tx_bytes[2] = 8'hFF;
    run_txn(1, 2, 0, 0);
    checks++;
    if (n_txhs != 3 || n_rx != 3) begin
      errors++;
      $display("FAIL basic_count: tx %0d rx %0d, expected 3/3", n_txhs, n_rx);
    end
    checks++;
    if (cs_bad || overlap) begin
      errors++;
      $display("FAIL basic_cs: cs_bad=%b overlap=%b, expected 0/0", cs_bad, overlap);
    end
    checks++;
    if (c_cslow != c_cmd + 1) begin
      errors++;
      $display("FAIL basic_cs_low: cycle %0d, expected %0d", c_cslow, c_cmd + 1);
    end
    checks++;
    if (c_req != c_cmd + GEFF + 1) begin
      errors++;
      $display("FAIL basic_first_req: cycle %0d, expected %0d", c_req, c_cmd + GEFF + 1);
    end
    checks++;
    if (c_cshigh != c_done + GEFF + 1) begin
      errors++;
      $display("FAIL basic_cs_high: cycle %0d, expected %0d", c_cshigh, c_done + GEFF + 1);
    end
  endtask

  task automatic test_single();
    tx_bytes[0] = 8'h5A;
    run_txn(0, 0, 0, 0);
    checks++;
    if (n_txhs != 1 || n_rx != 1) begin
      errors++;
      $display("FAIL single_count: tx %0d rx %0d, expected 1/1", n_txhs, n_rx);
    end
    checks++;
    if (c_cshigh != c_done + GEFF + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end: cs high at %0d busy=%b, expected %0d/0",
               c_cshigh, busy, c_done + GEFF + 1);
    end
  endtask

  task automatic test_rx_stall();
    for (int i = 0; i < 3; i++) tx_bytes[i] = 8'($urandom_range(0, 255));
    run_txn(0, 2, 60, 0);
    checks++;
    if (!stall_seen || stall_bad) begin
      errors++;
      $display("FAIL rx_stall: buffer_full_seen=%b req_while_full=%b, expected 1/0",
               stall_seen, stall_bad);
    end
    checks++;
    if (n_rx != 3) begin
      errors++;
      $display("FAIL rx_stall_count: rx %0d, expected 3", n_rx);
    end
  endtask

  task automatic test_tx_pause();
    for (int i = 0; i < 4; i++) tx_bytes[i] = 8'($urandom_range(0, 255));
    run_txn(1, 3, 0, 50);
    checks++;
    if (!pause_seen || pause_bad) begin
      errors++;
      $display("FAIL tx_pause: pause_done=%b cs_or_req_bad=%b, expected 1/0", pause_seen, pause_bad);
    end
    checks++;
    if (n_txhs != 4 || cs_bad) begin
      errors++;
      $display("FAIL tx_pause_end: tx %0d cs_bad=%b, expected 4/0", n_txhs, cs_bad);
    end
  endtask

  task automatic test_back_to_back();
    int first_high;
    tx_bytes[0] = 8'h12; tx_bytes[1] = 8'h34;
    run_txn(0, 1, 0, 0);
    first_high = c_cshigh;
    checks++;
    if (cs_bad) begin
      errors++;
      $display("FAIL b2b_cs0: cs_bad=%b, expected 0", cs_bad);
    end
    tx_bytes[0] = 8'h56; tx_bytes[1] = 8'h78;
    run_txn(1, 1, 0, 0);
    checks++;
    if (cs_bad || c_cslow <= first_high) begin
      errors++;
      $display("FAIL b2b_gap: cs_bad=%b low at %0d, expected 0 and after %0d",
               cs_bad, c_cslow, first_high);
    end
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 16; i++) tx_bytes[i] = 8'(i * 17 + 3);
    m_lat = 3;
    run_txn(1, (1 << LEN_W) - 1, 0, 0);
    m_lat = 12;
    checks++;
    if (n_txhs != 16 || n_rx != 16) begin
      errors++;
      $display("FAIL max_len: tx %0d rx %0d, expected 16/16", n_txhs, n_rx);
    end
  endtask

  task automatic test_reset_mid();
    int hs;
    hs = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_cs = '0; cmd_len = LEN_W'(3);
    #1;
    @(negedge clk);
    cmd_valid = 1'b0; tx_valid = 1'b1; tx_data = 8'h11; rx_ready = 1'b1;
    for (int k = 0; k < 500 && hs < 2; k++) begin
      @(negedge clk);
      #1;
      if (tx_valid && tx_ready) hs++;
    end
    checks++;
    if (hs != 2) begin
      errors++;
      $display("FAIL reset_mid_setup: %0d tx handshakes, expected 2", hs);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (cs_n !== '1 || rx_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: cs_n=%b rx_valid=%b cmd_ready=%b busy=%b, expected 11/0/1/0",
               cs_n, rx_valid, cmd_ready, busy);
    end
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_rx_stall();
    test_tx_pause();
    test_back_to_back();
    test_max_len();
    test_reset_mid();
    test_single();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
